// File: rtl/gsm_lpc_pkg.sv
// Shared constants, types and saturation helper for the GSM 06.10 LAR quantizer.
package gsm_lpc_pkg;

  localparam int LAR_W  = 16;
  localparam int LARC_W = 6;
  localparam int NCOEF  = 8;

  // Per-coefficient scale, offset and code range (LAR[1..8] at index 0..7).
  localparam logic [14:0] A_COEF [0:NCOEF-1] = '{
    15'd20480, 15'd20480, 15'd20480, 15'd20480,
    15'd13964, 15'd15360, 15'd8534,  15'd9036
  };
  localparam logic signed [15:0] B_COEF [0:NCOEF-1] = '{
    16'sd0,   16'sd0,     16'sd2048, -16'sd2560,
    16'sd94, -16'sd1792, -16'sd341,  -16'sd1144
  };
  localparam logic signed [7:0] MAC_COEF [0:NCOEF-1] = '{
    8'sd31, 8'sd31, 8'sd15, 8'sd15, 8'sd7, 8'sd7, 8'sd3, 8'sd3
  };
  localparam logic signed [7:0] MIC_COEF [0:NCOEF-1] = '{
    -8'sd32, -8'sd32, -8'sd16, -8'sd16, -8'sd8, -8'sd8, -8'sd4, -8'sd4
  };

  typedef struct packed {
    logic               valid;
    logic [2:0]         idx;
    logic               last;
    logic signed [30:0] p;
  } s1_t;

  function automatic logic signed [15:0] sat16(input logic signed [16:0] x);
    logic signed [15:0] r;
    if (x > 17'sd32767) begin
      r = 16'sh7fff;
    end else if (x < -17'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = x[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/gsm_lar_quantizer_if.sv
// Streaming LAR-in / LARc-out handshake bundle for the quantizer.
interface gsm_lar_quantizer_if;
  import gsm_lpc_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sof;
  logic signed [LAR_W-1:0] in_lar;
  logic                    out_valid;
  logic                    out_ready;
  logic [2:0]              out_idx;
  logic                    out_last;
  logic [LARC_W-1:0]       out_larc;
  logic                    sof_err;

  modport master (
    output in_valid, in_sof, in_lar, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_larc, sof_err
  );

  modport slave (
    input  in_valid, in_sof, in_lar, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_larc, sof_err
  );

endinterface

// File: rtl/gsm_lar_quant_mult.sv
// 15-bit unsigned x 16-bit signed product, bit-exact to GSM_MULT before the shift.
module gsm_lar_quant_mult (
  input  logic [14:0]        a,
  input  logic signed [15:0] b,
  output logic signed [30:0] p
);

  logic signed [30:0] a_ext_s;
  logic signed [30:0] b_ext_s;

  // Zero-extend the coefficient so the product is a plain signed multiply.
  always_comb begin
    a_ext_s = {16'd0, a};
    b_ext_s = {{15{b[15]}}, b};
    p       = a_ext_s * b_ext_s;
  end

endmodule

// File: rtl/gsm_lar_quantizer.sv
// GSM 06.10 LAR quantization/coding: multiply in S1, offset/round/clamp into S2.
module gsm_lar_quantizer
  import gsm_lpc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CODE_W = 6
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  gsm_lar_quantizer_if.slave bus
);

  logic                     en_s;
  logic                     accept_s;
  logic [2:0]               sample_idx_s;
  logic signed [DATA_W-1:0] lar_s;
  logic signed [30:0]       p_s;
  logic [2:0]               idx_r;
  s1_t                      s1_r;
  logic                     s2_valid_r;
  logic [2:0]               s2_idx_r;
  logic                     s2_last_r;
  logic [CODE_W-1:0]        s2_code_r;
  logic                     sof_err_r;

  logic signed [15:0]       t0_s;
  logic signed [15:0]       t1_s;
  logic signed [15:0]       t2_s;
  logic signed [6:0]        t3_s;
  logic signed [7:0]        t3x_s;
  logic signed [7:0]        mac_s;
  logic signed [7:0]        mic_s;
  logic [CODE_W-1:0]        code_s;

  assign lar_s = bus.in_lar;

  // Both stages advance together; an accepted frame start restarts the index.
  always_comb begin
    en_s     = !s2_valid_r || bus.out_ready;
    accept_s = bus.in_valid && en_s;
    if (bus.in_sof) begin
      sample_idx_s = 3'd0;
    end else begin
      sample_idx_s = idx_r;
    end
  end

  gsm_lar_quant_mult u_mult (
    .a (A_COEF[sample_idx_s]),
    .b (lar_s),
    .p (p_s)
  );

  // Floor shift, two saturating adds, rounding shift, then clamp into the code range.
  always_comb begin
    t0_s  = 16'($signed(s1_r.p) >>> 15);
    t1_s  = sat16({t0_s[15], t0_s} + {B_COEF[s1_r.idx][15], B_COEF[s1_r.idx]});
    t2_s  = sat16({t1_s[15], t1_s} + 17'sd256);
    t3_s  = 7'(t2_s >>> 9);
    t3x_s = {t3_s[6], t3_s};
    mac_s = MAC_COEF[s1_r.idx];
    mic_s = MIC_COEF[s1_r.idx];
    if (t3x_s > mac_s) begin
      code_s = CODE_W'(mac_s - mic_s);
    end else if (t3x_s < mic_s) begin
      code_s = {CODE_W{1'b0}};
    end else begin
      code_s = CODE_W'(t3x_s - mic_s);
    end
  end

  // Index counter, sof_err pulse and the two pipeline stages.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      idx_r      <= 3'd0;
      s1_r       <= '0;
      s2_valid_r <= 1'b0;
      s2_idx_r   <= 3'd0;
      s2_last_r  <= 1'b0;
      s2_code_r  <= {CODE_W{1'b0}};
      sof_err_r  <= 1'b0;
    end else begin
      sof_err_r <= accept_s && bus.in_sof && (idx_r != 3'd0);
      if (accept_s) begin
        idx_r <= sample_idx_s + 3'd1;
      end
      if (en_s) begin
        s1_r.valid <= accept_s;
        s1_r.idx   <= sample_idx_s;
        s1_r.last  <= (sample_idx_s == 3'd7);
        s1_r.p     <= p_s;
        s2_valid_r <= s1_r.valid;
        s2_idx_r   <= s1_r.idx;
        s2_last_r  <= s1_r.last;
        s2_code_r  <= code_s;
      end
    end
  end

  assign bus.in_ready  = en_s;
  assign bus.out_valid = s2_valid_r;
  assign bus.out_idx   = s2_idx_r;
  assign bus.out_last  = s2_last_r;
  assign bus.out_larc  = s2_code_r;
  assign bus.sof_err   = sof_err_r;

endmodule

// File: tb/tb_gsm_lar_quantizer.sv
// Directed self-checking bench for gsm_lar_quantizer with hand-computed LARc values.
module tb_gsm_lar_quantizer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gsm_lar_quantizer_if bus ();

  gsm_lar_quantizer #(.DATA_W(16), .CODE_W(6)) dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  // Frame stimulus and expected codes, one per coefficient index.
  logic signed [15:0] lar_tab [0:7] = '{16'sd32767, -16'sd32768, 16'sd1000, -16'sd32768,
                                        16'sd0, 16'sd0, 16'sd0, -16'sd1000};
  logic [5:0] larc_tab [0:7] = '{6'd63, 6'd0, 6'd21, 6'd0, 6'd8, 6'd5, 6'd3, 6'd1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_lar   = 16'sd0;
  endtask

  task automatic do_reset();
    idle();
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic sof, input logic signed [15:0] lar);
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_lar   = lar;
  endtask

  // Streams one frame; out_ready drops for stall_len cycles starting at cycle stall_at.
  task automatic run_frame(input int stall_at, input int stall_len);
    int sent;
    int recv;
    int cyc;
    int first_out;
    logic hold_prev;
    logic stall;
    logic [2:0] idx_prev;
    logic [5:0] larc_prev;
    logic last_prev;
    sent = 0; recv = 0; cyc = 0; first_out = -1; hold_prev = 1'b0;
    idx_prev = 3'd0; larc_prev = 6'd0; last_prev = 1'b0;
    while (recv < 8 && cyc < 40) begin
      bus.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      bus.in_valid  = (sent < 8);
      bus.in_sof    = (sent == 0);
      bus.in_lar    = lar_tab[sent % 8];
      #1;
      if (hold_prev) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_idx", 32'(bus.out_idx), 32'(idx_prev));
        check("hold_larc", 32'(bus.out_larc), 32'(larc_prev));
        check("hold_last", 32'(bus.out_last), 32'(last_prev));
      end
      if (bus.out_valid) begin
        if (first_out < 0) begin
          first_out = cyc;
          if (stall_len == 0) check("latency", 32'(cyc), 32'd2);
        end
        check("frame_idx", 32'(bus.out_idx), 32'(recv));
        check("frame_larc", 32'(bus.out_larc), 32'(larc_tab[recv % 8]));
        check("frame_last", 32'(bus.out_last), 32'(recv == 7));
      end
      stall = bus.out_valid && !bus.out_ready;
      if (stall) check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("frame_sof_err", 32'(bus.sof_err), 32'd0);
      hold_prev = stall;
      idx_prev  = bus.out_idx;
      larc_prev = bus.out_larc;
      last_prev = bus.out_last;
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) recv++;
      tick();
      cyc++;
    end
    check("frame_complete", 32'(recv), 32'd8);
    idle();
    bus.out_ready = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_idx", 32'(bus.out_idx), 32'd0);
    check("rst_last", 32'(bus.out_last), 32'd0);
    check("rst_larc", 32'(bus.out_larc), 32'd0);
    check("rst_sof_err", 32'(bus.sof_err), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single sample lar 0 at idx 0 -> 32, visible after the second edge
    drive(1'b1, 16'sd0);
    tick();
    idle();
    #1;
    check("single_early", 32'(bus.out_valid), 32'd0);
    tick();
    #1;
    check("single_valid", 32'(bus.out_valid), 32'd1);
    check("single_larc", 32'(bus.out_larc), 32'd32);
    check("single_idx", 32'(bus.out_idx), 32'd0);
    check("single_last", 32'(bus.out_last), 32'd0);
    tick();
    #1;
    check("single_drop", 32'(bus.out_valid), 32'd0);

    // Full frame without and then with backpressure
    do_reset();
    run_frame(99, 0);
    run_frame(3, 5);

    // sof at idx 3: pulse one cycle later, sample coded as idx 0
    do_reset();
    drive(1'b1, 16'sd0);
    tick();
    drive(1'b0, 16'sd0);
    #1;
    check("sof_idx0_silent", 32'(bus.sof_err), 32'd0);
    tick();
    drive(1'b0, 16'sd0);
    tick();
    drive(1'b1, 16'sd32767);
    tick();
    idle();
    #1;
    check("sof_err_pulse", 32'(bus.sof_err), 32'd1);
    check("sof_prev_idx", 32'(bus.out_idx), 32'd2);
    check("sof_prev_larc", 32'(bus.out_larc), 32'd20);
    drive(1'b0, 16'sd1000);
    tick();
    idle();
    #1;
    check("sof_err_clear", 32'(bus.sof_err), 32'd0);
    check("sof_valid", 32'(bus.out_valid), 32'd1);
    check("sof_tag_idx", 32'(bus.out_idx), 32'd0);
    check("sof_tag_larc", 32'(bus.out_larc), 32'd63);
    tick();
    #1;
    check("after_sof_idx", 32'(bus.out_idx), 32'd1);
    check("after_sof_larc", 32'(bus.out_larc), 32'd33);

    // Reset with both stages full
    do_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, lar_tab[0]);
    tick();
    drive(1'b0, 16'sd0);
    tick();
    idle();
    #1;
    check("full_valid", 32'(bus.out_valid), 32'd1);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    tick();
    #1;
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_idx", 32'(bus.out_idx), 32'd0);
    check("midrst_larc", 32'(bus.out_larc), 32'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, 16'sd1000);
    tick();
    idle();
    tick();
    #1;
    check("postrst_valid", 32'(bus.out_valid), 32'd1);
    check("postrst_idx", 32'(bus.out_idx), 32'd0);
    check("postrst_larc", 32'(bus.out_larc), 32'd33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
